// File: rtl/wb_retire_stage_pkg.sv
// Shared types and constants for the writeback/retire stage: default widths,
// exception codes and the default-width trace record layout.
package wb_retire_stage_pkg;

    localparam int WB_PC_W   = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_REG_AW = 5;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    typedef struct packed {
        logic [WB_PC_W-1:0]   pc;
        logic [3:0]           wen;
        logic [WB_REG_AW-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } trace_rec_t;

    // Trace consumers expect a byte-lane style enable, so the single bit is fanned out.
    function automatic logic [3:0] trace_wen(input logic we);
        return {4{we}};
    endfunction

endpackage

// File: rtl/wb_retire_stage_trace_fifo.sv
// Synchronous FIFO for retire trace records; one-cycle write-to-read latency.
// Backpressure: full blocks push, empty blocks pop; simultaneous push/pop legal.
module wb_trace_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: one stage register, 1 cycle accept-to-leave, regfile write and trace push on leave.
// Backpressure: a full trace FIFO holds the stage; ws_allowin depends only on registered state.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int PC_W     = WB_PC_W,
    parameter int DATA_W   = WB_DATA_W,
    parameter int REG_AW   = WB_REG_AW,
    parameter int DEPTH    = 4,
    parameter int TRACE_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_to_ws_valid,
    output logic              ws_allowin,
    input  logic [PC_W-1:0]   ms_pc,
    input  logic              ms_rf_we,
    input  logic [REG_AW-1:0] ms_dest,
    input  logic [DATA_W-1:0] ms_result,
    input  logic              ms_ex,
    input  logic [5:0]        ms_ecode,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              ws_fwd_valid,
    output logic [REG_AW-1:0] ws_fwd_dest,
    output logic [DATA_W-1:0] ws_fwd_data,
    output logic              ws_ex_flush,
    output logic [PC_W-1:0]   ws_ex_pc,
    output logic [5:0]        ws_ex_ecode,
    output logic              debug_wb_valid,
    input  logic              debug_wb_ready,
    output logic [PC_W-1:0]   debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [REG_AW-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata,
    output logic [31:0]       perf_retire_cnt
);
    localparam int REC_W = PC_W + 4 + REG_AW + DATA_W;

    logic              ws_valid_q, ws_valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ex_q, ex_d;
    logic [5:0]        ecode_q, ecode_d;
    logic [31:0]       perf_q, perf_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [REC_W-1:0]  fifo_head;
    logic [REC_W-1:0]  push_rec;
    logic              ws_ready_go;
    logic              accept;
    logic              leave;
    logic              retire_wen;

    assign ws_ready_go = !fifo_full;
    assign ws_allowin  = !ws_valid_q || ws_ready_go;
    assign accept      = ms_to_ws_valid && ws_allowin;
    assign leave       = ws_valid_q && ws_ready_go;
    assign retire_wen  = rf_we_q && !ex_q;

    assign rf_we        = leave && retire_wen;
    assign rf_waddr     = dest_q;
    assign rf_wdata     = result_q;
    assign ws_fwd_valid = ws_valid_q && retire_wen;
    assign ws_fwd_dest  = dest_q;
    assign ws_fwd_data  = result_q;
    assign ws_ex_flush  = leave && ex_q;
    assign ws_ex_pc     = pc_q;
    assign ws_ex_ecode  = ecode_q;
    assign perf_retire_cnt = perf_q;

    always_comb begin
        ws_valid_d = ws_valid_q;
        pc_d       = pc_q;
        rf_we_d    = rf_we_q;
        dest_d     = dest_q;
        result_d   = result_q;
        ex_d       = ex_q;
        ecode_d    = ecode_q;
        perf_d     = perf_q;
        // The flush pulse also squashes whatever memory stage offers in the same cycle.
        if (ws_ex_flush) begin
            ws_valid_d = 1'b0;
        end else if (accept) begin
            ws_valid_d = 1'b1;
            pc_d       = ms_pc;
            rf_we_d    = ms_rf_we;
            dest_d     = ms_dest;
            result_d   = ms_result;
            ex_d       = ms_ex;
            ecode_d    = ms_ecode;
        end else if (leave) begin
            ws_valid_d = 1'b0;
        end
        if (leave && !ex_q) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q <= 1'b0;
            pc_q       <= '0;
            rf_we_q    <= 1'b0;
            dest_q     <= '0;
            result_q   <= '0;
            ex_q       <= 1'b0;
            ecode_q    <= '0;
            perf_q     <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            pc_q       <= pc_d;
            rf_we_q    <= rf_we_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            ex_q       <= ex_d;
            ecode_q    <= ecode_d;
            perf_q     <= perf_d;
        end
    end

    assign push_rec = {pc_q, trace_wen(retire_wen), dest_q, result_q};

    generate
        if (TRACE_EN != 0) begin : g_trace
            wb_trace_fifo #(
                .DEPTH (DEPTH),
                .W     (REC_W)
            ) u_trace_fifo (
                .clk      (clk),
                .reset    (reset),
                .push     (leave),
                .push_dat (push_rec),
                .pop      (debug_wb_valid && debug_wb_ready),
                .pop_dat  (fifo_head),
                .full     (fifo_full),
                .empty    (fifo_empty)
            );
        end else begin : g_no_trace
            assign fifo_full  = 1'b0;
            assign fifo_empty = 1'b1;
            assign fifo_head  = {REC_W{1'b0}};
        end
    endgenerate

    // Head fields are masked while empty so stale storage never shows on the trace port.
    assign debug_wb_valid = !fifo_empty;
    assign {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata} =
        fifo_empty ? {REC_W{1'b0}} : fifo_head;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: a queue-based model checked every cycle plus directed literal checks,
// with a second instance built without the trace FIFO.
module tb_wb_retire_stage;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic        debug_wb_ready;

    logic        ws_allowin, rf_we, ws_fwd_valid, ws_ex_flush, debug_wb_valid;
    logic [4:0]  rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, ws_fwd_data, ws_ex_pc, debug_wb_pc, debug_wb_rf_wdata, perf_retire_cnt;
    logic [5:0]  ws_ex_ecode;
    logic [3:0]  debug_wb_rf_wen;

    logic        ws_allowin_1, rf_we_1, ws_fwd_valid_1, ws_ex_flush_1, debug_wb_valid_1;
    logic [4:0]  rf_waddr_1, ws_fwd_dest_1, debug_wb_rf_wnum_1;
    logic [31:0] rf_wdata_1, ws_fwd_data_1, ws_ex_pc_1, debug_wb_pc_1, debug_wb_rf_wdata_1, perf_retire_cnt_1;
    logic [5:0]  ws_ex_ecode_1;
    logic [3:0]  debug_wb_rf_wen_1;

    always #5 clk = ~clk;

    wb_retire_stage #(.PC_W(32), .DATA_W(32), .REG_AW(5), .DEPTH(DEPTH), .TRACE_EN(1)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_ex(ms_ex), .ms_ecode(ms_ecode), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_fwd_valid(ws_fwd_valid), .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data),
        .ws_ex_flush(ws_ex_flush), .ws_ex_pc(ws_ex_pc), .ws_ex_ecode(ws_ex_ecode),
        .debug_wb_valid(debug_wb_valid), .debug_wb_ready(debug_wb_ready), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata), .perf_retire_cnt(perf_retire_cnt)
    );

    wb_retire_stage #(.PC_W(32), .DATA_W(32), .REG_AW(5), .DEPTH(DEPTH), .TRACE_EN(0)) dut_nt (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin_1),
        .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_ex(ms_ex), .ms_ecode(ms_ecode), .rf_we(rf_we_1), .rf_waddr(rf_waddr_1), .rf_wdata(rf_wdata_1),
        .ws_fwd_valid(ws_fwd_valid_1), .ws_fwd_dest(ws_fwd_dest_1), .ws_fwd_data(ws_fwd_data_1),
        .ws_ex_flush(ws_ex_flush_1), .ws_ex_pc(ws_ex_pc_1), .ws_ex_ecode(ws_ex_ecode_1),
        .debug_wb_valid(debug_wb_valid_1), .debug_wb_ready(1'b0), .debug_wb_pc(debug_wb_pc_1),
        .debug_wb_rf_wen(debug_wb_rf_wen_1), .debug_wb_rf_wnum(debug_wb_rf_wnum_1),
        .debug_wb_rf_wdata(debug_wb_rf_wdata_1), .perf_retire_cnt(perf_retire_cnt_1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
        logic        ex;
        logic [5:0]  ecode;
    } ins_t;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  dest;
        logic [31:0] data;
    } rec_t;

    ins_t        st, st1, inp;
    bit          st_v, st1_v, model_on;
    rec_t        tq[$];
    int unsigned m_perf, m_perf1;
    logic [36:0] rf_log[$];
    rec_t        tr_log[$];

    // Model: one held instruction, a bounded record queue, and a retire counter.
    always @(negedge clk) begin
        bit   full, leave, acc, flush, exp_we, exp_fwd, exp_we1, exp_fwd1, flush1;
        rec_t r;
        inp = '{ms_pc, ms_rf_we, ms_dest, ms_result, ms_ex, ms_ecode};
        if (model_on) begin
            full    = (tq.size() == DEPTH);
            leave   = st_v && !full;
            acc     = ms_to_ws_valid && (!st_v || !full);
            flush   = leave && st.ex;
            exp_we  = leave && st.we && !st.ex;
            exp_fwd = st_v && st.we && !st.ex;
            chk("allowin", ws_allowin, !st_v || !full);
            chk("rf_we", rf_we, exp_we);
            if (exp_we) begin
                chk("rf_waddr", rf_waddr, st.dest);
                chk("rf_wdata", rf_wdata, st.res);
            end
            chk("fwd_valid", ws_fwd_valid, exp_fwd);
            if (exp_fwd) begin
                chk("fwd_dest", ws_fwd_dest, st.dest);
                chk("fwd_data", ws_fwd_data, st.res);
            end
            chk("ex_flush", ws_ex_flush, flush);
            if (flush) begin
                chk("ex_pc", ws_ex_pc, st.pc);
                chk("ex_ecode", ws_ex_ecode, st.ecode);
            end
            chk("trace_valid", debug_wb_valid, tq.size() != 0);
            if (tq.size() != 0) r = tq[0];
            else r = '{32'h0, 4'h0, 5'h0, 32'h0};
            chk("trace_pc", debug_wb_pc, r.pc);
            chk("trace_wen", debug_wb_rf_wen, r.wen);
            chk("trace_wnum", debug_wb_rf_wnum, r.dest);
            chk("trace_wdata", debug_wb_rf_wdata, r.data);
            chk("perf", perf_retire_cnt, m_perf);

            exp_we1  = st1_v && st1.we && !st1.ex;
            exp_fwd1 = exp_we1;
            flush1   = st1_v && st1.ex;
            chk("nt_allowin", ws_allowin_1, 1);
            chk("nt_trace_valid", debug_wb_valid_1, 0);
            chk("nt_trace_fields", |{debug_wb_pc_1, debug_wb_rf_wen_1, debug_wb_rf_wnum_1, debug_wb_rf_wdata_1}, 0);
            chk("nt_rf_we", rf_we_1, exp_we1);
            chk("nt_fwd_valid", ws_fwd_valid_1, exp_fwd1);
            chk("nt_ex_flush", ws_ex_flush_1, flush1);
            if (exp_we1) begin
                chk("nt_rf_waddr", rf_waddr_1, st1.dest);
                chk("nt_rf_wdata", rf_wdata_1, st1.res);
                chk("nt_fwd_dest", ws_fwd_dest_1, st1.dest);
                chk("nt_fwd_data", ws_fwd_data_1, st1.res);
            end
            if (flush1) begin
                chk("nt_ex_pc", ws_ex_pc_1, st1.pc);
                chk("nt_ex_ecode", ws_ex_ecode_1, st1.ecode);
            end
            chk("nt_perf", perf_retire_cnt_1, m_perf1);

            if (rf_we) rf_log.push_back({rf_waddr, rf_wdata});
            if (debug_wb_valid && debug_wb_ready)
                tr_log.push_back('{debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata});

            if (tq.size() != 0 && debug_wb_ready) void'(tq.pop_front());
            if (leave) tq.push_back('{st.pc, (st.we && !st.ex) ? 4'hF : 4'h0, st.dest, st.res});
            if (leave && !st.ex) m_perf++;
            if (flush) st_v = 0;
            else if (acc) begin st = inp; st_v = 1; end
            else if (leave) st_v = 0;

            if (st1_v && !st1.ex) m_perf1++;
            if (flush1) st1_v = 0;
            else if (ms_to_ws_valid) begin st1 = inp; st1_v = 1; end
            else st1_v = 0;
        end
        if (reset) begin
            model_on = 1;
            st_v = 0; st1_v = 0;
            tq.delete();
            m_perf = 0; m_perf1 = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ms(input logic [31:0] pc, input logic we, input logic [4:0] d,
                          input logic [31:0] r, input logic ex, input logic [5:0] ec);
        ms_pc = pc; ms_rf_we = we; ms_dest = d; ms_result = r; ms_ex = ex; ms_ecode = ec;
        ms_to_ws_valid = 1'b1;
    endtask

    task automatic accept_wait();
        int k = 0;
        while (!ws_allowin && k < 100) begin
            cyc();
            k++;
        end
        chk("accept_wait", ws_allowin, 1);
        cyc();
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        debug_wb_ready = 1'b1;
        cyc(); cyc();
        while (debug_wb_valid && k < 100) begin
            cyc();
            k++;
        end
        chk("drain", debug_wb_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    bit tog_on;

    initial begin
        logic [36:0] e;
        reset = 1'b1; ms_to_ws_valid = 1'b0; debug_wb_ready = 1'b1;
        ms_pc = '0; ms_rf_we = 0; ms_dest = '0; ms_result = '0; ms_ex = 0; ms_ecode = '0;
        cyc(); cyc();
        chk("rst_allowin", ws_allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_fwd_valid", ws_fwd_valid, 0);
        chk("rst_ex_flush", ws_ex_flush, 0);
        chk("rst_ex_pc", ws_ex_pc, 0);
        chk("rst_trace_valid", debug_wb_valid, 0);
        chk("rst_trace_pc", debug_wb_pc, 0);
        chk("rst_perf", perf_retire_cnt, 0);
        reset = 1'b0;

        // back-to-back retire with consumer always ready
        rf_log.delete(); tr_log.delete();
        for (int i = 1; i <= 6; i++) begin
            set_ms(32'h1c000000 + 32'(i * 4), 1'b1, 5'(i), 32'(i * 16), 1'b0, 6'h0);
            accept_wait();
        end
        cyc(); cyc(); cyc();
        chk("b2b_perf", perf_retire_cnt, 6);
        chk("b2b_nt_perf", perf_retire_cnt_1, 6);
        chk("b2b_rf_count", rf_log.size(), 6);
        chk("b2b_trace_count", tr_log.size(), 6);
        for (int i = 1; i <= 6; i++) begin
            e = {5'(i), 32'(i * 16)};
            if (rf_log.size() >= i) chk("b2b_rf_order", rf_log[i-1], e);
            if (tr_log.size() >= i) chk("b2b_trace_order", tr_log[i-1].data, 32'(i * 16));
        end

        // back-pressure: four records fill the FIFO, fifth instruction is held in the stage
        rf_log.delete(); tr_log.delete();
        debug_wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_ms(32'h1c001000 + 32'(i * 4), 1'b1, 5'(i), 32'h100 * 32'(i), 1'b0, 6'h0);
            accept_wait();
        end
        set_ms(32'h1c001018, 1'b1, 5'd6, 32'h600, 1'b0, 6'h0);
        cyc(); cyc();
        chk("bp_allowin", ws_allowin, 0);
        chk("bp_fwd_valid", ws_fwd_valid, 1);
        chk("bp_fwd_dest", ws_fwd_dest, 5);
        chk("bp_rf_count", rf_log.size(), 4);
        chk("bp_head_pc", debug_wb_pc, 32'h1c001004);
        chk("bp_nt_allowin", ws_allowin_1, 1);
        debug_wb_ready = 1'b1;
        accept_wait();
        drain();
        chk("bp_rf_total", rf_log.size(), 6);
        chk("bp_trace_total", tr_log.size(), 6);
        for (int i = 1; i <= 6; i++) begin
            if (rf_log.size() >= i) chk("bp_rf_order", rf_log[i-1], {5'(i), 32'h100 * 32'(i)});
            if (tr_log.size() >= i) chk("bp_trace_pc", tr_log[i-1].pc, 32'h1c001000 + 32'(i * 4));
        end

        // exception: flush pulse, no write, wen=0 trace, simultaneous offer dropped
        chk("ex_perf_before", perf_retire_cnt, 12);
        rf_log.delete(); tr_log.delete();
        set_ms(32'h1c000100, 1'b1, 5'd7, 32'h77, 1'b1, 6'h0B);
        accept_wait();
        set_ms(32'h1c000104, 1'b1, 5'd8, 32'h88, 1'b0, 6'h0);
        chk("ex_flush_pulse", ws_ex_flush, 1);
        chk("ex_pc_lit", ws_ex_pc, 32'h1c000100);
        chk("ex_ecode_lit", ws_ex_ecode, 6'h0B);
        chk("ex_no_rf_we", rf_we, 0);
        cyc();
        ms_to_ws_valid = 1'b0;
        chk("ex_flush_one_cycle", ws_ex_flush, 0);
        chk("ex_dropped", ws_fwd_valid, 0);
        chk("ex_trace_valid", debug_wb_valid, 1);
        chk("ex_trace_pc", debug_wb_pc, 32'h1c000100);
        chk("ex_trace_wen", debug_wb_rf_wen, 4'h0);
        cyc(); cyc();
        chk("ex_rf_count", rf_log.size(), 0);
        chk("ex_perf_after", perf_retire_cnt, 12);
        chk("ex_trace_count", tr_log.size(), 1);

        // pointer wrap: 3*DEPTH+1 records with ready toggling every cycle
        rf_log.delete(); tr_log.delete();
        debug_wb_ready = 1'b0;
        tog_on = 1;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH + 1; i++) begin
                    set_ms(32'h1c002000 + 32'(i * 4), 1'b1, 5'((i % 31) + 1), 32'h1000 + 32'(i), 1'b0, 6'h0);
                    accept_wait();
                end
                tog_on = 0;
            end
            begin
                while (tog_on) begin
                    cyc();
                    debug_wb_ready = ~debug_wb_ready;
                end
            end
        join
        drain();
        chk("wrap_trace_count", tr_log.size(), 3 * DEPTH + 1);
        chk("wrap_rf_count", rf_log.size(), 3 * DEPTH + 1);
        for (int i = 0; i < 3 * DEPTH + 1; i++)
            if (tr_log.size() > i) chk("wrap_trace_order", tr_log[i].data, 32'h1000 + 32'(i));

        // reset while FIFO holds three records and the stage is valid
        debug_wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_ms(32'h1c003000 + 32'(i * 4), 1'b1, 5'(i), 32'(i), 1'b0, 6'h0);
            accept_wait();
        end
        chk("mid_trace_valid", debug_wb_valid, 1);
        chk("mid_fwd_valid", ws_fwd_valid, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_trace_valid", debug_wb_valid, 0);
        chk("mid_rst_allowin", ws_allowin, 1);
        chk("mid_rst_perf", perf_retire_cnt, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_fwd", ws_fwd_valid, 0);
        chk("mid_rst_nt_perf", perf_retire_cnt_1, 0);
        debug_wb_ready = 1'b1;
        set_ms(32'h1c004000, 1'b1, 5'd3, 32'h33, 1'b0, 6'h0);
        accept_wait();
        cyc(); cyc();
        chk("post_rst_perf", perf_retire_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
Name: wb_retire_stage

Overview:
Parametrised writeback and retire stage for the 5-stage in-order CPU. It sits between the memory stage and the register file / trace interface.
- Holds one instruction in a stage register and writes the register file when the instruction leaves.
- Forwards the pending result to decode.
- Raises a one-cycle exception flush.
- Buffers retire trace records in a DEPTH-entry FIFO, so the difftest/trace consumer can back-pressure the pipeline.

Parameters:
PC_W, 32, PC width
DATA_W, 32, register data width
REG_AW, 5, register address width
DEPTH, 4, trace FIFO entries (power of two, >=2)
TRACE_EN, 1, 1 = trace FIFO present; 0 = FIFO removed, trace outputs tied to 0

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ms_to_ws_valid  in  1  memory stage has an instruction
ws_allowin  out  1  stage can accept this cycle
ms_pc  in  PC_W  instruction PC
ms_rf_we  in  1  instruction writes a register
ms_dest  in  REG_AW  destination register
ms_result  in  DATA_W  result value
ms_ex  in  1  instruction carries an exception
ms_ecode  in  6  exception code
rf_we  out  1  register file write enable
rf_waddr  out  REG_AW  register file write address
rf_wdata  out  DATA_W  register file write data
ws_fwd_valid  out  1  forwarding entry valid (to decode)
ws_fwd_dest  out  REG_AW  forwarding destination
ws_fwd_data  out  DATA_W  forwarding data
ws_ex_flush  out  1  exception flush pulse
ws_ex_pc  out  PC_W  faulting PC
ws_ex_ecode  out  6  exception code
debug_wb_valid  out  1  trace record valid
debug_wb_ready  in  1  trace consumer accepts
debug_wb_pc  out  PC_W  trace PC
debug_wb_rf_wen  out  4  trace write-enable, replicated
debug_wb_rf_wnum  out  REG_AW  trace destination
debug_wb_rf_wdata  out  DATA_W  trace data
perf_retire_cnt  out  32  retired non-exception instruction count

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset state:
  - ws_valid=0, FIFO empty, perf_retire_cnt=0.
  - All outputs 0, except ws_allowin=1.
- Handshake and staging:
  - ws_ready_go = !fifo_full when TRACE_EN=1; ws_ready_go = 1 when TRACE_EN=0.
  - ws_allowin = !ws_valid || ws_ready_go. This is purely registered-state based: there is no combinational path from debug_wb_ready.
  - Accept = ms_to_ws_valid && ws_allowin. On accept, the stage register loads all ms_* fields and ws_valid=1 next cycle.
  - Leave = ws_valid && ws_ready_go. Leave with no accept sets ws_valid=0.
  - Stage register latency is one cycle from accept to earliest leave.
- Register file write:
  - rf_we = leave && rf_we_q && !ex_q, asserted combinationally in the leave cycle.
  - Exactly one write per instruction, even across stall cycles.
  - Writes to register 0 are passed through; the register file ignores them.
- Forwarding:
  - ws_fwd_valid = ws_valid && rf_we_q && !ex_q. It stays valid while the stage is stalled.
  - ws_fwd_dest and ws_fwd_data come from the stage register.
- Exception:
  - ws_ex_flush = leave && ex_q, a single-cycle combinational pulse. ws_ex_pc and ws_ex_ecode are driven from the stage register.
  - In the flush cycle, ws_valid next = 0 and any simultaneous accept is discarded; upstream is flushed by the same pulse.
  - perf_retire_cnt is not incremented for excepting instructions.
- Trace FIFO (TRACE_EN=1):
  - Push on every leave, including excepting instructions, which push with wen=0.
  - Record = {pc, {4{rf_we_q && !ex_q}}, dest, result}.
  - Head is presented while non-empty: debug_wb_valid = !empty. Pop on debug_wb_valid && debug_wb_ready.
  - Read/write pointers are log2(DEPTH)+1 bits with natural wrap. Full = MSBs differ and the lower bits are equal.
  - Push and pop in the same cycle are legal when not full (count unchanged) and when full (pop frees a slot but the push is already blocked by ws_ready_go).
- perf_retire_cnt increments on leave && !ex_q and wraps at 2^32.
- Reset asserted mid-stall clears the stage register, the FIFO and the counter in the same edge; pending trace records are lost by design.

Decomposition:
- Shared package: ecode constants, the trace record typedef, and width defaults PC_W/DATA_W/REG_AW.
- One sub-module: wb_trace_fifo, a parametrised synchronous FIFO (DEPTH, record width) with full/empty outputs. The stage instantiates it only under TRACE_EN.

Test Plan:
- Back-to-back: 6 instructions, dest r1..r6, results 0x10..0x60, debug_wb_ready=1 → six single-cycle rf_we pulses in order, six trace records in order, perf_retire_cnt=6.
- Back-pressure: debug_wb_ready=0, DEPTH=4, 6 instructions offered:
  - Exactly 4 retire, then the 5th is held in the stage with ws_fwd_valid=1 and ws_allowin=0.
  - Raise ready → remaining records drain in order with no duplicate rf_we.
- Exception: instruction pc=0x1c000100, ex=1, ecode=0x0B, rf_we=1 → ws_ex_flush 1 cycle, ws_ex_pc=0x1c000100, no rf_we, trace wen=0000, counter unchanged, simultaneous ms_to_ws_valid dropped.
- Wrap: 3*DEPTH+1 push/pop cycles with alternating ready → pointer wrap with no lost or reordered records; full/empty flags correct at every boundary.
- Reset mid-operation: FIFO holding 3 records, stage valid, reset pulsed one cycle → next cycle debug_wb_valid=0, ws_allowin=1, perf_retire_cnt=0, rf_we=0.
- TRACE_EN=0 build: ready tied 0 → pipeline never stalls and debug_wb_valid stays 0.
